reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Top-of-hierarchy reset source. Sits directly upstream of the reset-supplying parent blocks and drives their `reset` inputs.
- Takes the board-level asynchronous active-low reset and synchronises its deassertion to `clk`.
- Releases NUM_OUT active-high synchronous resets one after another, with a fixed gap between them, so downstream stages (queues and their consumers) leave reset in dependency order.
- Also accepts a software reset request and reports when the whole sequence has completed.

Parameters:
- NUM_OUT, 3: number of staged reset outputs. Must be ≥1.
- SYNC_STAGES, 2: flops in the deassertion synchroniser. Must be ≥2.
- HOLD_CYCLES, 8: cycles all outputs stay asserted after the synchronised release. Must be ≥1.
- STAGE_GAP, 4: cycles between consecutive output releases. Must be ≥1.
- WDT_CYCLES, 64: watchdog timeout in cycles. Used only with the optional feature.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- sw_req  in  1  one-cycle software reset request, synchronous to clk
- rst_out  out  NUM_OUT  active-high resets; bit i feeds downstream stage i
- ready  out  1  high when every rst_out bit is released
- busy  out  1  high while in state HOLD or RELEASE

Behaviour:
- While reset=0 (asynchronous):
  - rst_out = all ones, ready=0, busy=0.
  - Synchroniser cleared; FSM forced to SYNC; all counters cleared.
- Synchroniser: asserts asynchronously, deasserts synchronously. Its output goes high at posedge SYNC_STAGES after reset rises. Edge 1 is the first posedge with reset=1.
- FSM states:
  - SYNC: waiting for synchroniser output = 1, then go to HOLD with cnt=0. rst_out all ones, busy=0.
  - HOLD: cnt increments every cycle. When cnt=HOLD_CYCLES-1, go to RELEASE with idx=0, cnt=0. rst_out all ones.
  - RELEASE: rst_out[0] clears on entry. Every STAGE_GAP cycles after that, the next bit clears (idx++). When bit NUM_OUT-1 has cleared, go to RUN.
  - RUN: rst_out=0, ready=1, busy=0.
- Required timing with defaults (registered outputs):
  - rst_out[0] falls at edge 10, rst_out[1] at edge 14, rst_out[2] at edge 18.
  - ready rises at edge 19.
  - General form: rst_out[i] falls at edge SYNC_STAGES+HOLD_CYCLES+i*STAGE_GAP. ready rises one edge after the last bit falls.
- Release order:
  - rst_out bits never release out of order.
  - A released bit stays released until a restart event.
- Restart events: sw_req=1 sampled in HOLD, RELEASE or RUN.
  - Next edge: rst_out = all ones, ready=0, state=HOLD, cnt=0.
  - sw_req in SYNC is ignored.
  - sw_req held high: the sequence keeps restarting (HOLD is re-entered each cycle).
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP, WDT_CYCLES)+1). No wrap is possible within legal parameters.
- Reset falling mid-sequence: immediate asynchronous return to the all-asserted SYNC condition, whatever the current state.

Optional Feature:
- Macro RESET_SEQ_WDT_EN.
- Defined:
  - Adds input wdt_kick (1 bit) and output wdt_fired (1 bit).
  - In RUN, a watchdog counter counts cycles. wdt_kick=1 clears it.
  - When the count reaches WDT_CYCLES-1 without a kick, it causes a restart identical to sw_req.
  - wdt_fired pulses high for exactly one cycle, coincident with re-entry to HOLD.
  - The watchdog counter is cleared outside RUN.
  - wdt_fired resets to 0.
- Undefined: neither port exists and there is no watchdog logic.

Decomposition:
- Package reset_seq_pkg:
  - state enum (SYNC, HOLD, RELEASE, RUN), 2 bits
  - localparam function computing the counter width
- Sub-module reset_sync: parameterised SYNC_STAGES-deep asynchronous-assert, synchronous-deassert synchroniser.
- reset_sequencer instantiates one reset_sync and contains the FSM and counters.

Test Plan:
1. Power-on, defaults, reset low 5 cycles then high → rst_out=3'b111 through edge 9; 3'b110 at edge 10; 3'b100 at edge 14; 3'b000 at edge 18; ready=1 at edge 19. busy=1 from edge 2 through edge 18.
2. In RUN, sw_req pulsed 1 cycle at edge 30 → edge 31: rst_out=3'b111, ready=0. rst_out[0] falls at edge 39, [1] at 43, [2] at 47; ready=1 at 48.
3. sw_req at edge 12, when rst_out=3'b110 → edge 13: rst_out=3'b111, HOLD restarted. rst_out[0] falls at edge 21.
4. reset driven low between edges during RELEASE, when rst_out=3'b100 → rst_out=3'b111 and ready=0 without waiting for an edge. After reset rises, the full sequence repeats with the timing of test 1.
5. Parameters NUM_OUT=1, STAGE_GAP=1, HOLD_CYCLES=1 → rst_out falls at edge 3; ready=1 at edge 4.
6. With RESET_SEQ_WDT_EN and WDT_CYCLES=64: no kick after ready → wdt_fired one-cycle pulse and rst_out all ones. Kicking every 32 cycles → wdt_fired stays 0 for 1000 cycles.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: FSM state type and counter sizing shared by the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;
  function automatic int cnt_width(int hold, int gap, int wdt);
    int m;
    m = hold > gap ? hold : gap;
    m = wdt > m ? wdt : m;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: STAGES-deep asynchronous-assert, synchronous-deassert reset synchroniser
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync,
  output logic sync_d
);
  logic [STAGES-1:0] ff;
  // shift ones in after release; clear immediately on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff <= '0;
    else ff <= {ff[STAGES-2:0], 1'b1};
  assign sync = ff[STAGES-1];
  assign sync_d = ff[STAGES-2];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of NUM_OUT resets after a synchronised board reset; optional watchdog via RESET_SEQ_WDT_EN
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_req,
`ifdef RESET_SEQ_WDT_EN
  input  logic               wdt_kick,
  output logic               wdt_fired,
`endif
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               busy
);
  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, WDT_CYCLES);
  localparam int IW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [NUM_OUT-1:0] rst_nx;
  logic sync, sync_d, restart, wdt_hit;
  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .sync(sync),
    .sync_d(sync_d)
  );
`ifdef RESET_SEQ_WDT_EN
  logic [CW-1:0] wdt_cnt;
  assign wdt_hit = state == RUN && !wdt_kick && wdt_cnt == CW'(WDT_CYCLES - 1);
  // idle-cycle counter in RUN; a kick or leaving RUN clears it, expiry pulses wdt_fired with the restart
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      wdt_cnt   <= state == RUN && !wdt_kick && !wdt_hit ? wdt_cnt + 1'b1 : '0;
      wdt_fired <= wdt_hit;
    end
`else
  assign wdt_hit = 1'b0;
`endif
  assign restart = sw_req || wdt_hit;
  // next state, counters and reset pattern; the penultimate synchroniser tap lets HOLD start on the edge the synchroniser output rises
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    case (state)
      SYNC: begin
        cnt_nx = '0;
        if (sync_d || sync) state_nx = HOLD;
      end
      HOLD:
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      RELEASE:
        if (idx == IW'(NUM_OUT - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else if (cnt == CW'(STAGE_GAP - 1)) begin
          idx_nx = idx + 1'b1;
          cnt_nx = '0;
        end
      default: cnt_nx = '0;
    endcase
    if (restart && state != SYNC) begin
      state_nx = HOLD;
      cnt_nx   = '0;
    end
    for (int i = 0; i < NUM_OUT; i++)
      rst_nx[i] = state_nx == RUN ? 1'b0 : state_nx != RELEASE || i > int'(idx_nx);
  end
  // state and registered outputs; everything asserted while the board reset is low
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= SYNC;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      rst_out <= rst_nx;
      ready   <= state_nx == RUN;
      busy    <= state_nx == HOLD || state_nx == RELEASE;
    end
endmodule
